// File: rtl/fetch_stage.sv
// Instruction fetch stage: keeps up to two instructions buffered (queued plus in flight) from a 1-cycle-latency instruction memory.
// Latency: request in cycle N, instruction presented to decode in cycle N+1 (the returning word falls through an empty queue).
// Backpressure: i_ready=0 holds the head stable; requests stop once queued + in-flight reaches 2, so no response is ever dropped.
//
// Ports:
//   i_clk, i_rst              clock, asynchronous active-high reset
//   o_imem_en, o_imem_addr    instruction memory read request / address
//   i_imem_data               read data, valid the cycle after the request
//   o_instruction, o_pc       head instruction word and its address
//   o_valid, i_ready          decode handshake, transfer = o_valid && i_ready
//   i_redirect, i_redirect_pc branch/jump redirect pulse and target
//   o_halted                  fetch stopped on a halt opcode
//
// Build option: define FETCH_HALT_EN to stop fetching when a word with
// opcode [15:12]=4'hF arrives. Without it, that opcode is ordinary data and
// o_halted is tied low.
module fetch_stage #(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    output logic              o_imem_en,
    output logic [ADDR_W-1:0] o_imem_addr,
    input  logic [15:0]       i_imem_data,
    output logic [15:0]       o_instruction,
    output logic [ADDR_W-1:0] o_pc,
    output logic              o_valid,
    input  logic              i_ready,
    input  logic              i_redirect,
    input  logic [ADDR_W-1:0] i_redirect_pc,
    output logic              o_halted
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] HALT = 2'd2;

    logic [1:0]        state;
    logic [ADDR_W-1:0] pc;
    logic              fly_vld;     // a response arrives on i_imem_data this cycle
    logic [ADDR_W-1:0] fly_pc;      // address of that response
    logic [1:0]        occ;         // queue occupancy, 0..2
    logic [15:0]       q0_dat, q1_dat;
    logic [ADDR_W-1:0] q0_pc, q1_pc;

    logic req;
    logic q_pop;
    logic bypass;
    logic q_push;
    logic halt_hit;

    // Credit check counts the response still in flight, so the queue can
    // always absorb it even if decode stalls.
    assign req = (state == RUN) && !i_redirect && ((occ + {1'b0, fly_vld}) < 2'd2);

    assign o_imem_en   = req;
    assign o_imem_addr = pc;

    // With the queue empty the returning word is presented directly; if
    // decode takes it in the same cycle it is never stored.
    assign o_valid       = (occ != 2'd0) || fly_vld;
    assign o_instruction = (occ == 2'd0 && fly_vld) ? i_imem_data : q0_dat;
    assign o_pc          = (occ == 2'd0 && fly_vld) ? fly_pc      : q0_pc;

    assign q_pop  = (occ != 2'd0) && i_ready;
    assign bypass = (occ == 2'd0) && fly_vld && i_ready;
    assign q_push = fly_vld && !bypass;

`ifdef FETCH_HALT_EN
    assign halt_hit = fly_vld && (i_imem_data[15:12] == 4'hF);
    assign o_halted = (state == HALT);
`else
    assign halt_hit = 1'b0;
    assign o_halted = 1'b0;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state   <= IDLE;
            pc      <= RESET_PC;
            fly_vld <= 1'b0;
            fly_pc  <= RESET_PC;
            occ     <= 2'd0;
            q0_dat  <= 16'h0000;
            q0_pc   <= RESET_PC;
            q1_dat  <= 16'h0000;
            q1_pc   <= RESET_PC;
        end else if (i_redirect) begin
            // Flush everything queued or returning; refetch starts next cycle.
            state   <= RUN;
            pc      <= i_redirect_pc;
            fly_vld <= 1'b0;
            occ     <= 2'd0;
        end else begin
            case (state)
                IDLE:    state <= RUN;
                RUN:     if (halt_hit) state <= HALT;
                default: state <= state;
            endcase

            if (req) begin
                pc     <= pc + 1'b1;
                fly_pc <= pc;
            end
            // A request issued alongside the arriving halt word is dropped.
            fly_vld <= req && !halt_hit;

            case ({q_push, q_pop})
                2'b10: begin
                    if (occ == 2'd0) begin
                        q0_dat <= i_imem_data;
                        q0_pc  <= fly_pc;
                    end else begin
                        q1_dat <= i_imem_data;
                        q1_pc  <= fly_pc;
                    end
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    q0_dat <= q1_dat;
                    q0_pc  <= q1_pc;
                    occ    <= occ - 2'd1;
                end
                2'b11: begin
                    if (occ == 2'd1) begin
                        q0_dat <= i_imem_data;
                        q0_pc  <= fly_pc;
                    end else begin
                        q0_dat <= q1_dat;
                        q0_pc  <= q1_pc;
                        q1_dat <= i_imem_data;
                        q1_pc  <= fly_pc;
                    end
                end
                default: occ <= occ;
            endcase
        end
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001: Parameter ADDR_W, default 8, instruction memory word-address width.
REQ-002: Parameter RESET_PC, default 0, first fetch address after reset.
REQ-003: i_clk  input  1  sole clock, all state updates on rising edge.
REQ-004: i_rst  input  1  reset, asynchronous, active-high.
REQ-005: o_imem_en  output  1  instruction memory read request.
REQ-006: o_imem_addr  output  ADDR_W  read address, valid when o_imem_en=1.
REQ-007: i_imem_data  input  16  read data, valid exactly one cycle after the request.
REQ-008: o_instruction  output  16  instruction word to decode stage.
REQ-009: o_pc  output  ADDR_W  address of o_instruction.
REQ-010: o_valid  output  1  o_instruction/o_pc hold a fetched instruction.
REQ-011: i_ready  input  1  decode stage accepts; transfer = o_valid && i_ready.
REQ-012: i_redirect  input  1  branch/jump redirect pulse.
REQ-013: i_redirect_pc  input  ADDR_W  redirect target address.
REQ-014: o_halted  output  1  fetch stopped by halt opcode.

Function
REQ-015: States SHALL be IDLE (after reset), RUN, HALT; IDLE -> RUN unconditionally after one cycle.
REQ-016: In RUN, a request SHALL issue when (queue occupancy + in-flight requests) < 2 and i_redirect=0; o_imem_addr = PC, PC <= PC+1 modulo 2^ADDR_W (max address wraps to 0).
REQ-017: Returned data SHALL be written with its address into a 2-entry FIFO queue the cycle after the request.
REQ-018: o_valid = queue non-empty; o_instruction/o_pc = queue head; head SHALL pop on transfer.
REQ-019: Simultaneous write and pop with queue full SHALL not occur (guaranteed by REQ-016); write and pop in same cycle on a 1-entry queue keeps occupancy 1.
REQ-020: With i_ready held 1, throughput SHALL be one instruction per cycle; first o_valid two cycles after the cycle reset deasserts... i.e. request in first RUN cycle, o_valid the following cycle.
REQ-021: o_valid, o_instruction, o_pc SHALL hold stable while o_valid=1 and i_ready=0.
REQ-022: Redirect cycle: a transfer occurring in that cycle completes; all remaining queue entries and any in-flight response SHALL be discarded; PC <= i_redirect_pc; no request issues; state <= RUN (also from HALT).
REQ-023: Cycle after redirect: o_valid=0, request issues at i_redirect_pc; its instruction is valid one cycle later.
REQ-024: Redirect during IDLE SHALL load PC with i_redirect_pc and proceed to RUN.

Reset
REQ-025: While i_rst=1, asynchronously: o_valid=0, o_instruction=16'h0000, o_pc=RESET_PC, o_imem_en=0, o_imem_addr=RESET_PC, o_halted=0, queue empty, in-flight cleared, PC=RESET_PC, state IDLE.
REQ-026: Reset asserted mid-operation SHALL discard queue contents and the in-flight response; data returning after reset is ignored.

Configuration
REQ-027: Macro FETCH_HALT_EN defined: when a word with [15:12]=4'hF is written into the queue, state SHALL go to HALT, no further requests issue, any in-flight response after it is discarded, o_halted=1; the halt word itself is delivered to decode; exit only via redirect or reset (o_halted<=0).
REQ-028: Macro undefined: opcode 4'hF is fetched as ordinary data, HALT unreachable, o_halted tied 0; port list unchanged.

Verification
REQ-029: Reset release, memory data = address, i_ready=1 -> o_pc 0,1,2,3... on consecutive cycles, o_instruction 16'h0000,0001,...
REQ-030: i_ready=0 for 5 cycles at PC 3 -> o_pc=3 held, o_imem_en low after queue holds 2; on release o_pc 3,4,5 back-to-back, no gaps/duplicates.
REQ-031: i_redirect with target 8'h40 while queue full -> next cycle o_valid=0, o_imem_addr=8'h40; following cycle o_pc=8'h40; old entries never appear.
REQ-032: ADDR_W=8, fetch through 8'hFF -> next o_pc=8'h00.
REQ-033: FETCH_HALT_EN, word 16'hF000 at address 5 -> o_pc 5 delivered, o_halted=1, no requests; redirect to 8'h10 -> o_halted=0, fetch resumes at 8'h10; without macro, address 6 follows 5.
REQ-034: i_rst pulsed mid-stream with response in flight -> outputs at reset values immediately, fetch restarts at RESET_PC, stale response not delivered.
